// File: rtl/load_wb_arbiter.sv
// Load writeback arbiter: merges cache-hit and miss-refill load responses onto one
// registered writeback/commit port, hit first, with a starvation guard for refills.
module load_wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int ROB_IDX_W    = 5,
   parameter int PRD_W        = 6,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 h_valid,
   output logic                 h_ready,
   input  logic [ROB_IDX_W-1:0] h_rob_idx,
   input  logic [PRD_W-1:0]     h_prd,
   input  logic                 h_wen,
   input  logic [XLEN-1:0]      h_data,
   input  logic                 r_valid,
   output logic                 r_ready,
   input  logic [ROB_IDX_W-1:0] r_rob_idx,
   input  logic [PRD_W-1:0]     r_prd,
   input  logic                 r_wen,
   input  logic [XLEN-1:0]      r_data,
   input  logic                 r_err,
   output logic                 wb_valid,
   output logic [ROB_IDX_W-1:0] wb_rob_idx,
   output logic [PRD_W-1:0]     wb_prd,
   output logic [XLEN-1:0]      wb_data,
   output logic                 commit_valid,
   output logic [ROB_IDX_W-1:0] commit_rob_idx,
   output logic                 commit_err
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]           r_starve_cnt;
   logic                 r_wb_valid;
   logic                 r_commit_valid;
   logic                 r_commit_err;
   logic [ROB_IDX_W-1:0] r_rob_idx_q;
   logic [PRD_W-1:0]     r_prd_q;
   logic [XLEN-1:0]      r_data_q;

   logic                 w_force_refill;
   logic                 w_h_grant;
   logic                 w_r_grant;
   logic [3:0]           w_starve_nxt;
   logic                 w_sel_wb;
   logic                 w_sel_err;
   logic [ROB_IDX_W-1:0] w_sel_rob;
   logic [PRD_W-1:0]     w_sel_prd;
   logic [XLEN-1:0]      w_sel_data;

   // Ready/grant decision; rst gates both readies so nothing transfers during reset.
   always_comb begin
      w_force_refill = (r_starve_cnt == LIMIT) && r_valid;
      h_ready        = !rst && !flush && !w_force_refill;
      r_ready        = !rst && !flush && (w_force_refill || !h_valid);
      w_h_grant      = h_valid && h_ready;
      w_r_grant      = r_valid && r_ready;
   end

   // Starvation counter next value: counts refill-waiting cycles, saturates at LIMIT.
   always_comb begin
      w_starve_nxt = 4'd0;
      if (flush || !r_valid || w_r_grant) begin
         w_starve_nxt = 4'd0;
      end else if (r_starve_cnt >= LIMIT) begin
         w_starve_nxt = LIMIT;
      end else begin
         w_starve_nxt = r_starve_cnt + 4'd1;
      end
   end

   // Payload mux of the granted source; a refill bus error suppresses the register write.
   always_comb begin
      w_sel_wb   = 1'b0;
      w_sel_err  = 1'b0;
      w_sel_rob  = h_rob_idx;
      w_sel_prd  = h_prd;
      w_sel_data = h_data;
      if (w_r_grant) begin
         w_sel_wb   = r_wen && !r_err;
         w_sel_err  = r_err;
         w_sel_rob  = r_rob_idx;
         w_sel_prd  = r_prd;
         w_sel_data = r_data;
      end else begin
         w_sel_wb   = h_wen;
         w_sel_err  = 1'b0;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= 4'd0;
      end else begin
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Output registers: valids pulse per grant, payload holds between grants.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid     <= 1'b0;
         r_commit_valid <= 1'b0;
         r_commit_err   <= 1'b0;
         r_rob_idx_q    <= '0;
         r_prd_q        <= '0;
         r_data_q       <= '0;
      end else if (w_h_grant || w_r_grant) begin
         r_wb_valid     <= w_sel_wb;
         r_commit_valid <= 1'b1;
         r_commit_err   <= w_sel_err;
         r_rob_idx_q    <= w_sel_rob;
         r_prd_q        <= w_sel_prd;
         r_data_q       <= w_sel_data;
      end else begin
         r_wb_valid     <= 1'b0;
         r_commit_valid <= 1'b0;
      end
   end

   assign wb_valid       = r_wb_valid;
   assign wb_rob_idx     = r_rob_idx_q;
   assign wb_prd         = r_prd_q;
   assign wb_data        = r_data_q;
   assign commit_valid   = r_commit_valid;
   assign commit_rob_idx = r_rob_idx_q;
   assign commit_err     = r_commit_err;

endmodule

// File: doc/load_wb_arbiter.md
LOAD_WB_ARBITER -- requirements
Module: load_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of the load writeback bus.
REQ-002 Parameter ROB_IDX_W, default 5, ROB index width.
REQ-003 Parameter PRD_W, default 6, physical destination register index width.
REQ-004 Parameter STARVE_LIMIT, default 4, max consecutive cycles refill may wait while hit is granted; legal range 1..15.
REQ-005 clk  input  1  single core clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  pipeline flush (mispredict/exception); synchronous kill.
REQ-008 h_valid / h_ready  input / output  1 / 1  cache-hit load response handshake.
REQ-009 h_rob_idx, h_prd, h_wen, h_data  input  ROB_IDX_W, PRD_W, 1, XLEN  hit response payload.
REQ-010 r_valid / r_ready  input / output  1 / 1  miss-refill load response handshake.
REQ-011 r_rob_idx, r_prd, r_wen, r_data, r_err  input  ROB_IDX_W, PRD_W, 1, XLEN, 1  refill payload; r_err = bus error.
REQ-012 wb_valid, wb_rob_idx, wb_prd, wb_data  output  1, ROB_IDX_W, PRD_W, XLEN  registered load writeback broadcast (register read, ALU groups, AGU).
REQ-013 commit_valid, commit_rob_idx, commit_err  output  1, ROB_IDX_W, 1  registered load completion to ROB.

Function
REQ-014 The block SHALL grant at most one source per cycle; transfer occurs when valid && ready on that source.
REQ-015 Default priority: hit over refill.
REQ-016 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle r_valid=1 and refill not granted; clear on refill grant or r_valid=0.
REQ-017 force_refill = (starve_cnt == STARVE_LIMIT) && r_valid; when set, refill SHALL be granted and h_ready=0 regardless of h_valid.
REQ-018 h_ready = !flush && !force_refill (combinational, independent of h_valid).
REQ-019 r_ready = !flush && (force_refill || !h_valid).
REQ-020 Latency: granted request at cycle N SHALL appear on outputs in cycle N+1; no output backpressure.
REQ-021 commit_valid SHALL be 1 in N+1 for every grant; commit_rob_idx = source rob_idx; commit_err = r_err for refill, 0 for hit.
REQ-022 wb_valid SHALL be 1 in N+1 only if the granted source's wen=1 and (for refill) r_err=0; wb_prd/wb_data/wb_rob_idx carry the granted payload.
REQ-023 Cycle with no grant SHALL drive wb_valid=0 and commit_valid=0 next cycle; payload outputs hold last value.
REQ-024 flush=1: both readies 0, no grant, starve_cnt cleared to 0, wb_valid/commit_valid forced to 0 next cycle (an in-flight registered output in the flush cycle itself is still presented).
REQ-025 Simultaneous h_valid and r_valid with starve_cnt < STARVE_LIMIT: hit granted, starve_cnt+1.
REQ-026 After a forced refill grant, starve_cnt = 0 and hit priority resumes the following cycle.

Reset
REQ-027 On rst=1 (asynchronous): wb_valid=0, commit_valid=0, commit_err=0, starve_cnt=0, all payload registers 0.
REQ-028 Reset asserted mid-transfer SHALL drop the pending output; no grant while rst=1 (h_ready=r_ready=0).
REQ-029 First grant possible in the first rising edge after rst deasserts.

Verification
REQ-030 Hit only: h_valid=1, rob 3, prd 10, wen=1, data 0xDEADBEEF at cycle N -> cycle N+1 wb_valid=1, prd 10, data 0xDEADBEEF, commit_valid=1, rob 3, err 0.
REQ-031 Starvation: h_valid and r_valid held high, STARVE_LIMIT=4 -> hit granted cycles 0-3, cycle 4 h_ready=0, r_ready=1, refill granted, cycle 5 hit again.
REQ-032 Refill bus error: r_valid=1, r_err=1, wen=1, rob 7 -> next cycle wb_valid=0, commit_valid=1, commit_rob_idx=7, commit_err=1.
REQ-033 Flush: starve_cnt=3, flush=1 one cycle with both valid -> no grant, next cycle wb_valid=commit_valid=0, starve_cnt=0; hit granted the cycle after.
REQ-034 Hit with wen=0 (load to x0): -> next cycle wb_valid=0, commit_valid=1.
REQ-035 Async reset asserted between clock edges with wb_valid=1 -> wb_valid, commit_valid drop to 0 immediately without a clock edge.
